// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared state encoding and default counter width for the clock-gate controller
package clk_gate_pkg;
  localparam int CLK_GATE_CNT_W = 8;
  typedef enum logic [1:0] {
    OFF  = 2'd0,
    WAKE = 2'd1,
    ON   = 2'd2,
    IDLE = 2'd3
  } state_t;
endpackage

// File: rtl/clk_gate_ctrl_if.sv
// clk_gate_ctrl_if: requester handshake plus gated-clock status between requesters and the controller
interface clk_gate_ctrl_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic clk_en;
  logic clk_out;
  logic busy;
  modport master(output req, input ack, clk_en, clk_out, busy);
  modport slave(input req, output ack, clk_en, clk_out, busy);
endinterface

// File: rtl/clk_gate_cell.sv
// clk_gate_cell: glitch-free latch-based clock gate, enable captured only while clk_in is low
module clk_gate_cell (
  input  logic clk_in,
  input  logic en,
  output logic clk_out
);
  logic en_l;
  // latch is transparent in the low phase so enable changes never reach clk_out mid-pulse
  always_latch
    if (!clk_in) en_l = en;
  assign clk_out = clk_in & en_l;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: wake/hold/idle-timeout sequencer for a gated clock domain; optional CLK_GATE_CTRL_TEST_EN adds test_en to force the clock on
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_CYCLES = 8,
  parameter int CNT_W       = CLK_GATE_CNT_W
) (
  input  logic clk_in,
  input  logic rst,
`ifdef CLK_GATE_CTRL_TEST_EN
  input  logic test_en,
`endif
  clk_gate_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] WAKE_M1 = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_M1 = CNT_W'(IDLE_CYCLES - 1);
  if (WAKE_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_bad_cycles
    $error("clk_gate_ctrl: WAKE_CYCLES and IDLE_CYCLES must be >= 1");
  end
  if (NUM_REQ < 1 || NUM_REQ > 16) begin : g_bad_req
    $error("clk_gate_ctrl: NUM_REQ must be 1..16");
  end
  if ((WAKE_CYCLES - 1) >= (1 << CNT_W) || (IDLE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt
    $error("clk_gate_ctrl: CNT_W too narrow for WAKE_CYCLES/IDLE_CYCLES");
  end
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic fsm_en;
  logic [NUM_REQ-1:0] ack;
  logic gate_en;
  logic gclk;
  // sequencer: OFF -> WAKE (fixed run-in, never aborted) -> ON (ack mirrors req) -> IDLE (timeout back to OFF)
  always_ff @(posedge clk_in or posedge rst)
    if (rst) begin
      state  <= OFF;
      cnt    <= '0;
      fsm_en <= 1'b0;
      ack    <= '0;
    end else begin
      case (state)
        OFF:
          if (|bus.req) begin
            state  <= WAKE;
            fsm_en <= 1'b1;
            cnt    <= WAKE_M1;
          end
        WAKE:
          if (cnt == '0) state <= ON;
          else cnt <= cnt - CNT_W'(1);
        ON: begin
          ack <= bus.req;
          if (bus.req == '0) begin
            state <= IDLE;
            cnt   <= IDLE_M1;
          end
        end
        IDLE:
          if (|bus.req) state <= ON;
          else if (cnt == '0) begin
            state  <= OFF;
            fsm_en <= 1'b0;
          end else cnt <= cnt - CNT_W'(1);
        default: state <= OFF;
      endcase
    end
`ifdef CLK_GATE_CTRL_TEST_EN
  assign gate_en = fsm_en | test_en;
`else
  assign gate_en = fsm_en;
`endif
  clk_gate_cell u_cell (
    .clk_in (clk_in),
    .en     (gate_en),
    .clk_out(gclk)
  );
  assign bus.ack     = ack;
  assign bus.clk_en  = gate_en;
  assign bus.clk_out = gclk;
  assign bus.busy    = (state != OFF);
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: directed checks of wake latency, idle timeout, re-request, multi-requester and async reset
module tb_clk_gate_ctrl;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
`ifdef CLK_GATE_CTRL_TEST_EN
  logic test_en = 1'b0;
`endif
  int checks = 0;
  int failures = 0;
  int rise_cnt = 0;
  time t_edge = 0;
  time last_rise = 0;
  time prev_rise = 0;
  time last_fall = 0;
  clk_gate_ctrl_if #(.NUM_REQ(4)) bus ();
  clk_gate_ctrl #(.NUM_REQ(4), .WAKE_CYCLES(2), .IDLE_CYCLES(8)) dut (
    .clk_in(clk_in),
    .rst   (rst),
`ifdef CLK_GATE_CTRL_TEST_EN
    .test_en(test_en),
`endif
    .bus   (bus)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) t_edge = $time;
  always @(posedge bus.clk_out) begin
    prev_rise = last_rise;
    last_rise = $time;
    rise_cnt++;
  end
  always @(negedge bus.clk_out) last_fall = $time;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    bus.req = 4'b0000;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_clk_en", 32'(bus.clk_en), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_clk_out", 32'(bus.clk_out), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    bus.req = 4'b0001;
    rise_cnt = 0;
    step();
    chk("wake_e0_clk_en", 32'(bus.clk_en), 32'd1);
    chk("wake_e0_busy", 32'(bus.busy), 32'd1);
    chk("wake_e0_ack", 32'(bus.ack), 32'd0);
    chk("wake_e0_rises", 32'(rise_cnt), 32'd0);
    step();
    chk("wake_e1_rises", 32'(rise_cnt), 32'd1);
    chk("wake_e1_rise_t", 32'(last_rise), 32'(t_edge));
    chk("wake_e1_ack", 32'(bus.ack), 32'd0);
    step();
    chk("wake_e2_ack", 32'(bus.ack), 32'd0);
    chk("wake_period", 32'(last_rise - prev_rise), 32'd10);
    step();
    chk("wake_e3_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    step();
    chk("idle_ack", 32'(bus.ack), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd1);
    rise_cnt = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("idle_en_%0d", i), 32'(bus.clk_en), 32'd1);
    end
    step();
    chk("idle_off_en", 32'(bus.clk_en), 32'd0);
    chk("idle_off_busy", 32'(bus.busy), 32'd0);
    step();
    chk("idle_rises", 32'(rise_cnt), 32'd8);
    chk("idle_last_pulse", 32'(last_fall - last_rise), 32'd5);
    bus.req = 4'b0001;
    repeat (3) step();
    step();
    chk("rereq_wake_ack", 32'(bus.ack), 32'b0001);
    bus.req = 4'b0000;
    step();
    chk("rereq_idle_ack", 32'(bus.ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rereq_idle_en_%0d", i), 32'(bus.clk_en), 32'd1);
    end
    bus.req = 4'b0100;
    step();
    chk("rereq_on_ack", 32'(bus.ack), 32'd0);
    chk("rereq_on_en", 32'(bus.clk_en), 32'd1);
    chk("rereq_on_busy", 32'(bus.busy), 32'd1);
    step();
    chk("rereq_ack", 32'(bus.ack), 32'b0100);
    chk("rereq_ack_en", 32'(bus.clk_en), 32'd1);
    bus.req = 4'b0011;
    step();
    chk("multi_0011", 32'(bus.ack), 32'b0011);
    bus.req = 4'b0010;
    step();
    chk("multi_0010", 32'(bus.ack), 32'b0010);
    bus.req = 4'b0000;
    step();
    chk("multi_0000", 32'(bus.ack), 32'd0);
    chk("multi_idle_busy", 32'(bus.busy), 32'd1);
    repeat (7) step();
    chk("multi_pre_off_busy", 32'(bus.busy), 32'd1);
    step();
    chk("multi_off_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0001;
    repeat (3) step();
    bus.req = 4'b0000;
    step();
    chk("drop_at_on_ack", 32'(bus.ack), 32'd0);
    step();
    chk("drop_at_on_ack2", 32'(bus.ack), 32'd0);
    chk("drop_at_on_busy", 32'(bus.busy), 32'd1);
    bus.req = 4'b0001;
    repeat (2) step();
    chk("pre_rst_ack", 32'(bus.ack), 32'b0001);
    @(negedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_clk_en", 32'(bus.clk_en), 32'd0);
    chk("arst_ack", 32'(bus.ack), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_clk_out", 32'(bus.clk_out), 32'd0);
    step();
    chk("arst_hold_clk_out", 32'(bus.clk_out), 32'd0);
    @(negedge clk_in);
    rst = 1'b0;
    step();
    chk("rewake_e0_en", 32'(bus.clk_en), 32'd1);
    chk("rewake_e0_ack", 32'(bus.ack), 32'd0);
    repeat (2) step();
    chk("rewake_e2_ack", 32'(bus.ack), 32'd0);
    step();
    chk("rewake_e3_ack", 32'(bus.ack), 32'b0001);
`ifdef CLK_GATE_CTRL_TEST_EN
    @(negedge clk_in);
    rst = 1'b1;
    bus.req = 4'b0000;
    @(negedge clk_in);
    rst = 1'b0;
    test_en = 1'b1;
    rise_cnt = 0;
    repeat (3) step();
    chk("test_rises", 32'(rise_cnt), 32'd3);
    chk("test_busy", 32'(bus.busy), 32'd0);
    chk("test_ack", 32'(bus.ack), 32'd0);
    test_en = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Sequences a gated clock domain driven by the team's clock buffer.
- Up to NUM_REQ requesters ask for the clock through a req/ack handshake.
- The controller wakes the gated clock, holds it while any requester is active, and turns it off after a programmable idle timeout.
- Output gating uses a glitch-free latch-based cell, so the gated clock has the same period as the source and only buffer-level phase delay.

Parameters:
- NUM_REQ, 4, number of requesters (1..16)
- WAKE_CYCLES, 2, clk_in cycles the gated clock runs before any ack is issued (>=1)
- IDLE_CYCLES, 8, consecutive no-request cycles in ON before the clock turns off (>=1)
- CNT_W, 8, counter width; must hold max(WAKE_CYCLES, IDLE_CYCLES)

Ports:
- clk_in  input  1  free-running source clock
- rst  input  1  asynchronous reset, active-high
- req  input  NUM_REQ  per-requester clock request, level
- ack  output  NUM_REQ  per-requester grant: gated clock is stable
- clk_en  output  1  registered enable into the gate cell
- clk_out  output  1  gated clock
- busy  output  1  high whenever state != OFF

Behaviour:
- Reset (async, rst=1): state=OFF, counter=0, clk_en=0, ack=0, busy=0. clk_out is held low immediately.
- Reset release is used synchronously; the first evaluation happens on the first clk_in posedge with rst=0.
- State encoding: OFF, WAKE, ON, IDLE. Everything is posedge clk_in.
- OFF:
  - clk_en=0.
  - If |req: go to WAKE, clk_en<=1, counter<=WAKE_CYCLES-1.
- WAKE:
  - If counter==0: go to ON; otherwise decrement.
  - req is ignored here, so a WAKE is never aborted and clock pulses are never truncated.
- ON:
  - ack[i]<=req[i] each cycle, registered, so there is 1 cycle of latency on both assert and deassert.
  - If req==0: go to IDLE, counter<=IDLE_CYCLES-1. All ack are 0 from the same edge.
- IDLE:
  - clk_en stays 1 and ack=0.
  - If |req: go to ON with no rewake; ack follows 1 cycle after ON is entered.
  - Else if counter==0: go to OFF, clk_en<=0.
  - Else decrement.
- Latency, measured from the edge E that samples req in OFF:
  - clk_en=1 after E.
  - State=ON after E+WAKE_CYCLES.
  - ack after E+WAKE_CYCLES+1.
- Simultaneous events:
  - All asserted requesters are acked together. There is no priority: the gated clock is a shared, non-exclusive resource.
  - If req drops in the same cycle that ON is entered, IDLE follows and no ack is ever raised.
- Handshake rules:
  - A requester must hold req until it sees ack, and must not clock logic on clk_out before ack.
  - Deasserting req before ack is legal; the request is then treated as withdrawn.
- Gate cell:
  - A latch is transparent while clk_in=0, capturing clk_en.
  - clk_out = clk_in AND latched enable. The output is glitch-free for any clk_en timing relative to posedge.
- busy = (state != OFF).
- Parameter checks: WAKE_CYCLES=0 or IDLE_CYCLES=0 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro CLK_GATE_CTRL_TEST_EN.
- When defined:
  - Adds input port test_en (1 bit).
  - clk_en = fsm_en OR test_en, combinational OR before the gate cell, so clk_out runs freely during test.
  - The FSM and ack behave exactly as without the macro; busy reflects only the FSM.
- When undefined: the port is absent and clk_en is the FSM register alone.

Decomposition:
- Package clk_gate_pkg holds:
  - the state typedef (OFF=2'd0, WAKE=2'd1, ON=2'd2, IDLE=2'd3);
  - constant CLK_GATE_CNT_W default.
- Sub-module clk_gate_cell (ports clk_in, en, clk_out) contains only the latch and the AND. It is reused by other gated domains.
- The top level holds the FSM, counter and ack registers.

Test Plan:
- Wake latency:
  - Stimulus: reset, then req=4'b0001 sampled at edge 0, defaults WAKE=2, IDLE=8.
  - Required: clk_en=1 after edge 0; first clk_out rising edge at edge 1; ack=4'b0001 after edge 3. The clk_out period measured over two edges equals the clk_in period (10 ns).
- Idle timeout:
  - Stimulus: drop req in ON.
  - Required: ack=0 after the next edge; clk_en stays 1 for exactly 8 cycles and then falls; busy falls with clk_en; clk_out shows no runt pulse.
- Re-request during IDLE:
  - Stimulus: drop req, then raise req=4'b0100 after 3 IDLE cycles.
  - Required: no wake sequence; ack=4'b0100 two edges after req is sampled (one edge to ON, one to ack); clk_en never drops.
- Multi-requester:
  - Stimulus: req goes 4'b0011 → 4'b0010 → 4'b0000.
  - Required: ack follows one cycle behind each change; IDLE is entered only at 4'b0000.
- Async reset mid-ON:
  - Stimulus: assert rst at mid-cycle while clk_in is low.
  - Required: clk_en, ack and busy go to 0 without waiting for an edge; clk_out stays low. After release with req held, a full wake sequence repeats.
- Test mode (CLK_GATE_CTRL_TEST_EN):
  - Stimulus: test_en=1 with req=0.
  - Required: clk_out toggles continuously while busy=0 and ack=0.
